// File: rtl/countdown_timer_bank_if.sv
// countdown_timer_bank_if: control, load and status signals of the countdown timer bank.
interface countdown_timer_bank_if #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 2
);
    logic                      tick;
    logic [CHANNELS-1:0]       start;
    logic [CHANNELS-1:0]       cancel;
    logic [CHANNELS-1:0]       pause;
    logic [CHANNELS-1:0]       reload;
    logic [CHANNELS*WIDTH-1:0] load_value;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       done;
    logic [CHANNELS-1:0]       expired;

    modport master (
        output tick, start, cancel, pause, reload, load_value,
        input  count, busy, done, expired
    );

    modport slave (
        input  tick, start, cancel, pause, reload, load_value,
        output count, busy, done, expired
    );
endinterface

// File: rtl/countdown_timer_bank.sv
// countdown_timer_bank: independent tick-driven countdown channels with
// one-shot or auto-reload mode, pause and cancel; channels never interact.
module countdown_timer_bank #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 2
) (
    input logic                   clk,
    input logic                   reset,
    countdown_timer_bank_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t           state_q, state_d;
        logic [WIDTH-1:0] count_q, count_d, reload_val_q, reload_val_d, ld;
        logic             mode_q, mode_d, expired_q, expired_d;

        assign ld = bus.load_value[c*WIDTH +: WIDTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q      <= IDLE;
                count_q      <= '0;
                reload_val_q <= '0;
                mode_q       <= 1'b0;
                expired_q    <= 1'b0;
            end else begin
                state_q      <= state_d;
                count_q      <= count_d;
                reload_val_q <= reload_val_d;
                mode_q       <= mode_d;
                expired_q    <= expired_d;
            end
        end

        // start > cancel > pause > tick
        always_comb begin
            state_d      = state_q;
            count_d      = count_q;
            reload_val_d = reload_val_q;
            mode_d       = mode_q;
            expired_d    = 1'b0;
            if (bus.start[c]) begin
                reload_val_d = ld;
                mode_d       = bus.reload[c];
                count_d      = ld;
                expired_d    = (ld == '0);
                state_d      = (ld == '0) ? DONE : (bus.pause[c] ? HOLD : RUN);
            end else if (bus.cancel[c]) begin
                state_d = IDLE;
                count_d = '0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (bus.pause[c]) begin
                            state_d = HOLD;
                        end else if (bus.tick) begin
                            if (count_q > WIDTH'(1)) begin
                                count_d = count_q - WIDTH'(1);
                            end else begin
                                expired_d = 1'b1;
                                count_d   = mode_q ? reload_val_q : '0;
                                state_d   = mode_q ? RUN : DONE;
                            end
                        end
                    end
                    HOLD:    state_d = bus.pause[c] ? HOLD : RUN;
                    default: ;
                endcase
            end
        end

        assign bus.count[c*WIDTH +: WIDTH] = count_q;
        assign bus.busy[c]                 = (state_q == RUN) || (state_q == HOLD);
        assign bus.done[c]                 = (state_q == DONE);
        assign bus.expired[c]              = expired_q;
    end
endmodule

// File: doc/countdown_timer_bank.md
Name: countdown_timer_bank

Overview:
- Bank of CHANNELS independent countdown timers sharing one clock and one tick-enable. Each channel supports one-shot or auto-reload mode, pause and cancel.
- Replaces per-chamber single countdown counters in the lock controller, e.g. 300/420/480 s pressurise, drain and fill intervals.
- A 1 Hz tick from the clock divider drives the count. The controller FSM consumes the per-channel done level and expired pulse.

Parameters:
- WIDTH, 10, bit width of each channel's count and load value (must be >=2).
- CHANNELS, 2, number of independent timer channels (must be >=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; clears every channel.
- tick  input  1  count enable; a channel decrements only on cycles with tick=1.
- start  input  CHANNELS  per-channel start/restart strobe.
- cancel  input  CHANNELS  per-channel abort strobe.
- pause  input  CHANNELS  per-channel level; while high the count is frozen.
- reload  input  CHANNELS  per-channel mode, sampled at start: 0=one-shot, 1=auto-reload.
- load_value  input  CHANNELS*WIDTH  start value; channel i uses bits [i*WIDTH +: WIDTH].
- count  output  CHANNELS*WIDTH  current remaining count per channel, registered.
- busy  output  CHANNELS  1 while the channel is in RUN or HOLD.
- done  output  CHANNELS  level; 1 while the channel is in DONE.
- expired  output  CHANNELS  single-cycle pulse on each expiry, in both modes.

Behaviour:
- Per-channel FSM: IDLE, RUN, HOLD, DONE. Encoding is free. Channels never interact.
- Reset: every channel goes to IDLE. count=0, busy=0, done=0, expired=0. Latched reload value and latched mode are cleared.
- Priority per channel, per cycle: reset > start > cancel > pause > tick.
- start (any state): latch load_value slice into the reload register and latch the reload bit. count<=load_value.
  - If load_value!=0: go to RUN, or to HOLD if pause=1 in the same cycle.
  - If load_value==0: go to DONE and pulse expired; mode is ignored.
  - Any tick in the start cycle is ignored.
- cancel (without start): go to IDLE with count=0. No expired pulse.
- RUN, with pause=1: go to HOLD. Count unchanged; tick ignored.
- RUN, with tick=1 and count>1: count<=count-1.
- RUN, with tick=1 and count==1:
  - One-shot: count<=0, go to DONE, expired=1 that cycle.
  - Auto-reload: count<=latched reload value, stay in RUN, expired=1 that cycle.
- HOLD: count frozen. pause=0 returns to RUN on the next edge. A tick in the release cycle is not counted.
- DONE: count=0, done=1 until start or cancel. tick and pause have no effect.
- IDLE: count=0. Only start leaves this state.
- Latency:
  - start to busy: 1 cycle.
  - Last tick to done/expired: 1 cycle (registered).
  - A one-shot load of N expires on the N-th counted tick after start.
  - Auto-reload with load N pulses expired every N counted ticks.
- expired is registered and high for exactly one clk cycle per expiry, even if tick stays high.
- Changes on load_value or reload while a channel is running have no effect until the next start.
- Arithmetic is unsigned WIDTH-bit. No wrap-around: count never decrements below 0. Maximum load is 2^WIDTH-1.
- Reset mid-run: immediate return to IDLE on that edge. No expired pulse.

Test Plan:
- Reset, then idle 10 cycles -> every count=0, busy=done=expired=0. Assert reset during a RUN with count=57 -> next cycle count=0, busy=0, no expired.
- Ch0 one-shot, load 300, tick every cycle -> count reads 300,299,…,1,0. done and expired both rise on the edge of the 300th tick. expired is high exactly 1 cycle; done holds; busy falls together.
- Ch1 auto-reload, load 3, tick every 4th cycle -> count sequence 3,2,1,3,2,1,3. expired pulses once per 3 ticks. done stays 0. cancel -> count=0, busy=0.
- Ch0 load 5: 2 ticks, then pause high for 6 ticks, then release -> count held at 3 during pause. done after 3 further ticks, i.e. 5 unpaused ticks total.
- Ch0 start with load 0 -> done=1 and expired pulse the next cycle. start+cancel in the same cycle -> start wins. start+tick in the same cycle -> count equals load, not load-1.
- Ch0 load 420 and ch1 load 480, started together -> ch0 done after 420 ticks while ch1 count=60. ch1 done 60 ticks later. A restart of ch1 mid-count does not disturb ch0.
